hilo_muldiv: RTL and testbench

- Multi-cycle multiply/divide unit that produces the HI/LO register pair for the MIPS pipeline.
- The EX-stage ALU is the consumer: it reads HI/LO for mfhi/mflo. This block is the writer, and stalls the pipeline while a result is pending.
- Replaces the single-cycle {hi,lo} <= A*B path with an iterative radix-2 engine supporting signed/unsigned mult and div.

---
 rtl/hilo_pkg.sv | 21 ++
 rtl/hilo_if.sv | 40 ++++
 rtl/hilo_signfix.sv | 20 ++
 rtl/hilo_muldiv.sv | 173 +++++++++++++++++
 tb/tb_hilo_muldiv.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared encodings, state enum and constants for the HI/LO multiply/divide unit.
package hilo_pkg;

  localparam int DEFAULT_XLEN = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_e;

  localparam logic [DEFAULT_XLEN-1:0] DIV0_QUOT = {DEFAULT_XLEN{1'b1}};

endpackage

// File: rtl/hilo_if.sv
// hilo_if: pipeline <-> multiply/divide unit bundle; the HI/LO move-to write port
// exists only when HILO_MTHILO_EN is defined.
interface hilo_if #(
  parameter int XLEN = hilo_pkg::DEFAULT_XLEN
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            rd_req;
  logic            busy;
  logic            done;
  logic            stall;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
`ifdef HILO_MTHILO_EN
  logic            mthi;
  logic            mtlo;
  logic [XLEN-1:0] wdata;

  modport master (
    output start, op, a, b, flush, rd_req, mthi, mtlo, wdata,
    input  busy, done, stall, hi, lo
  );
  modport slave (
    input  start, op, a, b, flush, rd_req, mthi, mtlo, wdata,
    output busy, done, stall, hi, lo
  );
`else
  modport master (
    output start, op, a, b, flush, rd_req,
    input  busy, done, stall, hi, lo
  );
  modport slave (
    input  start, op, a, b, flush, rd_req,
    output busy, done, stall, hi, lo
  );
`endif
endinterface

// File: rtl/hilo_signfix.sv
// hilo_signfix: conditional two's-complement negate, used both to take operand
// magnitudes at latch time and to restore result signs at FIN.
module hilo_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  // Negate when requested, pass through otherwise
  always_comb begin
    if (neg) begin
      dout = ~din + {{(W-1){1'b0}}, 1'b1};
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative radix-2 multiply/divide unit that writes the MIPS HI/LO pair.
// Define HILO_MTHILO_EN to add the mthi/mtlo/wdata move-to write path.
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int ITERS = XLEN
) (
  input logic   clk,
  input logic   rst_n,
  hilo_if.slave bus
);

  localparam int CNT_W = $clog2(ITERS + 1);

  state_e            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              is_div_r;
  logic              neg_q_r;
  logic              neg_r_r;
  logic              div0_r;
  logic [XLEN-1:0]   opnd_r;
  logic [XLEN-1:0]   acc_hi_r;
  logic [XLEN-1:0]   acc_lo_r;
  logic [XLEN-1:0]   hi_r;
  logic [XLEN-1:0]   lo_r;
  logic              busy_r;
  logic              done_r;

  logic              signed_s;
  logic              is_div_s;
  logic [XLEN-1:0]   abs_a_s;
  logic [XLEN-1:0]   abs_b_s;
  logic [XLEN:0]     mul_sum_s;
  logic [XLEN:0]     div_shift_s;
  logic              div_borrow_s;
  logic [XLEN-1:0]   div_diff_s;
  logic [XLEN-1:0]   step_hi_s;
  logic [XLEN-1:0]   step_lo_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s;
  logic [XLEN-1:0]   rem_fix_s;
  logic              wr_req_s;

  // Decode the requested operation into signedness and mult/div selection
  always_comb begin
    signed_s = 1'b0;
    is_div_s = 1'b0;
    case (bus.op)
      OP_MULTU: begin signed_s = 1'b0; is_div_s = 1'b0; end
      OP_MULT:  begin signed_s = 1'b1; is_div_s = 1'b0; end
      OP_DIVU:  begin signed_s = 1'b0; is_div_s = 1'b1; end
      OP_DIV:   begin signed_s = 1'b1; is_div_s = 1'b1; end
      default:  begin signed_s = 1'b0; is_div_s = 1'b0; end
    endcase
  end

  hilo_signfix #(.W(XLEN)) u_abs_a (
    .din(bus.a), .neg(signed_s & bus.a[XLEN-1]), .dout(abs_a_s)
  );
  hilo_signfix #(.W(XLEN)) u_abs_b (
    .din(bus.b), .neg(signed_s & bus.b[XLEN-1]), .dout(abs_b_s)
  );
  hilo_signfix #(.W(2*XLEN)) u_fix_prod (
    .din({acc_hi_r, acc_lo_r}), .neg(neg_q_r), .dout(prod_fix_s)
  );
  hilo_signfix #(.W(XLEN)) u_fix_quo (
    .din(acc_lo_r), .neg(neg_q_r), .dout(quo_fix_s)
  );
  hilo_signfix #(.W(XLEN)) u_fix_rem (
    .din(acc_hi_r), .neg(neg_r_r), .dout(rem_fix_s)
  );

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
  // A zero divisor never borrows, so the quotient fills with ones and the remainder ends as |a|.
  always_comb begin
    mul_sum_s    = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
    div_shift_s  = {acc_hi_r, acc_lo_r[XLEN-1]};
    div_borrow_s = (div_shift_s < {1'b0, opnd_r});
    div_diff_s   = div_shift_s[XLEN-1:0] - opnd_r;
    if (is_div_r) begin
      step_hi_s = div_borrow_s ? div_shift_s[XLEN-1:0] : div_diff_s;
      step_lo_s = {acc_lo_r[XLEN-2:0], ~div_borrow_s};
    end else begin
      step_hi_s = mul_sum_s[XLEN:1];
      step_lo_s = {mul_sum_s[0], acc_lo_r[XLEN-1:1]};
    end
  end

`ifdef HILO_MTHILO_EN
  assign wr_req_s = bus.mthi | bus.mtlo;
`else
  assign wr_req_s = 1'b0;
`endif

  assign bus.stall = busy_r & (bus.start | bus.rd_req | wr_req_s);
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;

  // Control FSM with registered busy/done and the HI/LO result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      div0_r   <= 1'b0;
      opnd_r   <= {XLEN{1'b0}};
      acc_hi_r <= {XLEN{1'b0}};
      acc_lo_r <= {XLEN{1'b0}};
      hi_r     <= {XLEN{1'b0}};
      lo_r     <= {XLEN{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
`ifdef HILO_MTHILO_EN
          if (bus.mthi) hi_r <= bus.wdata;
          if (bus.mtlo) lo_r <= bus.wdata;
`endif
          if (bus.start && !bus.flush) begin
            state_r  <= RUN;
            busy_r   <= 1'b1;
            cnt_r    <= {CNT_W{1'b0}};
            is_div_r <= is_div_s;
            neg_q_r  <= signed_s & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
            neg_r_r  <= signed_s & bus.a[XLEN-1];
            div0_r   <= (bus.b == {XLEN{1'b0}});
            acc_hi_r <= {XLEN{1'b0}};
            // Multiply: a is the addend, b is shifted out; divide: a is shifted in, b subtracted
            opnd_r   <= is_div_s ? abs_b_s : abs_a_s;
            acc_lo_r <= is_div_s ? abs_a_s : abs_b_s;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            acc_hi_r <= step_hi_s;
            acc_lo_r <= step_lo_s;
            cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_r == CNT_W'(ITERS - 1)) state_r <= FIN;
          end
        end
        FIN: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          if (!bus.flush) begin
            done_r <= 1'b1;
            if (is_div_r) begin
              hi_r <= rem_fix_s;
              lo_r <= div0_r ? XLEN'(DIV0_QUOT) : quo_fix_s;
            end else begin
              hi_r <= prod_fix_s[2*XLEN-1:XLEN];
              lo_r <= prod_fix_s[XLEN-1:0];
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed-vector self-checking bench for hilo_muldiv
// (extra move-to checks when HILO_MTHILO_EN is defined).
module tb_hilo_muldiv;
  import hilo_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  hilo_if #(.XLEN(32)) bus ();

  hilo_muldiv #(.XLEN(32), .ITERS(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge, wait for done, check latency, busy length, result and HI/LO hold.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int cyc;
    int bcyc;
    int moved;
    logic [31:0] h0;
    logic [31:0] l0;
    h0 = bus.hi; l0 = bus.lo; cyc = 0; bcyc = 0; moved = 0;
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
      if (bus.busy) bcyc++;
      if (!bus.done && (bus.hi !== h0 || bus.lo !== l0)) moved++;
    end while (!bus.done && cyc < 100);
    chk({tag, ".lat"}, 64'(cyc), 64'd34);
    chk({tag, ".busy"}, 64'(bcyc), 64'd33);
    chk({tag, ".hold"}, 64'(moved), 64'd0);
    chk({tag, ".hi"}, {32'd0, bus.hi}, {32'd0, ehi});
    chk({tag, ".lo"}, {32'd0, bus.lo}, {32'd0, elo});
  endtask

  initial begin
    int cyc;
    int miss;
    int ndone;
    total = 0; bad = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = 32'd0; bus.b = 32'd0;
    bus.flush = 1'b0; bus.rd_req = 1'b0;
`ifdef HILO_MTHILO_EN
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = 32'd0;
`endif
    repeat (2) @(negedge clk);
    chk("rst.hi", {32'd0, bus.hi}, 64'd0);
    chk("rst.lo", {32'd0, bus.lo}, 64'd0);
    chk("rst.busy", {63'd0, bus.busy}, 64'd0);
    chk("rst.done", {63'd0, bus.done}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_z",    OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF);
    run_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000);
    run_op("div_z",     OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("divu",      OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
    run_op("div_negb",  OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
    run_op("mult_min",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0);
    run_op("multu",     OP_MULTU, 32'h12345678, 32'h10,       32'd1,        32'h23456780);

    // rd_req plus a second start at cycle 10 of RUN: stall until done, second start dropped
    bus.op = OP_MULTU; bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
    cyc = 0; miss = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) bus.start = 1'b0;
      if (cyc > 10 && !bus.done && !bus.stall) miss++;
      if (cyc == 10) begin
        bus.rd_req = 1'b1; bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd9; bus.b = 32'd9;
        #1 chk("stall.rise", {63'd0, bus.stall}, 64'd1);
      end
    end while (!bus.done && cyc < 100);
    chk("stall.lat", 64'(cyc), 64'd34);
    chk("stall.held", 64'(miss), 64'd0);
    chk("stall.done", {63'd0, bus.stall}, 64'd0);
    chk("stall.lo", {32'd0, bus.lo}, 64'd15);
    bus.start = 1'b0; bus.rd_req = 1'b0;
    @(negedge clk);
    chk("stall.ign", {63'd0, bus.busy}, 64'd0);

    // Flush mid-RUN keeps the earlier 0x11/0x22 result and produces no done
    run_op("pre", OP_MULTU, 32'h80000001, 32'h22, 32'h11, 32'h22);
    bus.op = OP_DIVU; bus.a = 32'd1000; bus.b = 32'd3; bus.start = 1'b1;
    repeat (5) begin @(negedge clk); bus.start = 1'b0; end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush.busy", {63'd0, bus.busy}, 64'd0);
    ndone = 0;
    repeat (40) begin @(negedge clk); if (bus.done) ndone++; end
    chk("flush.done", 64'(ndone), 64'd0);
    chk("flush.hi", {32'd0, bus.hi}, 64'h11);
    chk("flush.lo", {32'd0, bus.lo}, 64'h22);

    // Async reset mid-RUN clears everything immediately
    bus.op = OP_MULTU; bus.a = 32'd5; bus.b = 32'd6; bus.start = 1'b1;
    repeat (10) begin @(negedge clk); bus.start = 1'b0; end
    rst_n = 1'b0;
    #1;
    chk("arst.hi", {32'd0, bus.hi}, 64'd0);
    chk("arst.lo", {32'd0, bus.lo}, 64'd0);
    chk("arst.busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin @(negedge clk); if (bus.done) ndone++; end
    chk("arst.done", 64'(ndone), 64'd0);
    run_op("post", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

`ifdef HILO_MTHILO_EN
    bus.mthi = 1'b1; bus.wdata = 32'hABCD;
    @(negedge clk);
    bus.mthi = 1'b0;
    chk("mthi.hi", {32'd0, bus.hi}, 64'hABCD);
    bus.op = OP_MULTU; bus.a = 32'd2; bus.b = 32'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.mtlo = 1'b1; bus.wdata = 32'h5A5A;
    #1 chk("mtlo.stall", {63'd0, bus.stall}, 64'd1);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!bus.done && cyc < 100);
    chk("mtlo.res", {32'd0, bus.lo}, 64'd6);
    @(negedge clk);
    bus.mtlo = 1'b0;
    chk("mtlo.lo", {32'd0, bus.lo}, 64'h5A5A);
    chk("mtlo.hi", {32'd0, bus.hi}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
